// File: rtl/data_bus_responder_pkg.sv
// Shared data-bus definitions: size codes, default memory map, FSM encodings.
package data_bus_responder_pkg;

  localparam logic [1:0] DBUS_SIZE_BYTE = 2'b00;
  localparam logic [1:0] DBUS_SIZE_HALF = 2'b01;
  localparam logic [1:0] DBUS_SIZE_WORD = 2'b10;
  localparam logic [1:0] DBUS_SIZE_RSVD = 2'b11;

  // Default data-memory placement, also used by the core's bus controller.
  localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0000_0000;
  localparam int          DMEM_DEPTH_DEFAULT = 1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Encoding/alignment part of the fault check (range is checked by the caller).
  function automatic logic size_align_fault(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      DBUS_SIZE_BYTE: size_align_fault = 1'b0;
      DBUS_SIZE_HALF: size_align_fault = a[0];
      DBUS_SIZE_WORD: size_align_fault = |a;
      default:        size_align_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_byte_lane.sv
// Little-endian lane steering: byte enables, write replication, read extract.
module data_byte_lane
  import data_bus_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] rdata
);

  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;

  // Enables and replicated write data; reserved size enables nothing.
  always_comb begin
    be   = 4'b0000;
    wrep = wdata;
    case (size)
      DBUS_SIZE_BYTE: begin
        be   = 4'b0001 << a_lo;
        wrep = {4{wdata[7:0]}};
      end
      DBUS_SIZE_HALF: begin
        be   = a_lo[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      DBUS_SIZE_WORD: be = 4'b1111;
      default:        be = 4'b0000;
    endcase
  end

  // Select the addressed lane(s) and zero-extend; sign extension is the core's job.
  always_comb begin
    case (a_lo)
      2'd0:    w_rbyte = rword[7:0];
      2'd1:    w_rbyte = rword[15:8];
      2'd2:    w_rbyte = rword[23:16];
      default: w_rbyte = rword[31:24];
    endcase
    w_rhalf = a_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      DBUS_SIZE_BYTE: rdata = {24'b0, w_rbyte};
      DBUS_SIZE_HALF: rdata = {16'b0, w_rhalf};
      default:        rdata = rword;
    endcase
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory slave: single outstanding access, fixed wait states, lane alignment.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_DEFAULT,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wd,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] data_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_rd, r_wd, r_fault;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_dout;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_idle, w_accept, w_enter_resp;
  logic        w_rd, w_wd, w_fault, w_oor;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_off, w_rdata, w_wrep;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_be;

  // In IDLE the live request is the one being decided; afterwards the captured one.
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & (rd | wd);
  assign w_rd     = w_idle ? rd      : r_rd;
  assign w_wd     = w_idle ? wd      : r_wd;
  assign w_size   = w_idle ? size    : r_size;
  assign w_addr   = w_idle ? addr    : r_addr;
  assign w_wdata  = w_idle ? data_in : r_wdata;

  // BASE_ADDR is aligned to the array size, so the offset's low bits equal addr's.
  assign w_off   = w_addr - BASE_ADDR;
  assign w_oor   = |w_off[31:AW+2];
  assign w_idx   = w_off[AW+1:2];
  assign w_fault = (w_rd & w_wd) | size_align_fault(w_size, w_off[1:0]) | w_oor;

  // Faults bypass the wait states so the initiator hears about them immediately.
  assign w_enter_resp = (w_accept & (w_fault | (WAIT_STATES == 0))) |
                        ((r_state == ST_WAIT) & (r_cnt == 4'd0));

  data_byte_lane u_lane (
    .size  (w_size),
    .a_lo  (w_off[1:0]),
    .wdata (w_wdata),
    .rword (r_mem[w_idx]),
    .be    (w_be),
    .wrep  (w_wrep),
    .rdata (w_rdata)
  );

  // FSM, request capture and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wd    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_fault <= 1'b0;
      r_dout  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_rd    <= rd;
          r_wd    <= wd;
          r_size  <= size;
          r_addr  <= addr;
          r_wdata <= data_in;
          r_fault <= w_fault;
          if (w_fault || (WAIT_STATES == 0)) r_state <= ST_RESP;
          else begin
            r_state <= ST_WAIT;
            r_cnt   <= 4'(WAIT_STATES - 1);
          end
        end
        ST_WAIT: if (r_cnt == 4'd0) r_state <= ST_RESP;
                 else               r_cnt   <= r_cnt - 4'd1;
        default: r_state <= ST_IDLE;
      endcase
      if (w_enter_resp && w_rd && !w_fault) r_dout <= w_rdata;
    end
  end

  // Memory commit on the edge into RESP; never reset, and reset aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_wd && !w_fault) begin
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
    end
  end

  assign ready    = w_idle;
  assign busy     = ~w_idle;
  assign done     = (r_state == ST_RESP);
  assign fault    = done & r_fault;
  assign data_out = r_dout;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench: directed table, random accesses vs byte-array model, corner sequences.
module tb_data_bus_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          DEP  = 1024;
  localparam int          WS   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WAIT_STATES=1, non-zero base
  logic        rst1 = 1'b1, rd1 = 1'b0, wd1 = 1'b0;
  logic [1:0]  size1 = 2'b0;
  logic [31:0] addr1 = 32'h0, din1 = 32'h0;
  logic        ready1, busy1, done1, fault1;
  logic [31:0] dout1;

  // DUT B: WAIT_STATES=0, for back-to-back throughput
  logic        rst0 = 1'b1, rd0 = 1'b0, wd0 = 1'b0;
  logic [1:0]  size0 = 2'b0;
  logic [31:0] addr0 = 32'h0, din0 = 32'h0;
  logic        ready0, busy0, done0, fault0;
  logic [31:0] dout0;

  data_bus_responder #(.DEPTH_WORDS(DEP), .BASE_ADDR(BASE), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .rst(rst1), .rd(rd1), .wd(wd1), .size(size1), .addr(addr1), .data_in(din1),
    .ready(ready1), .busy(busy1), .done(done1), .fault(fault1), .data_out(dout1));

  data_bus_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst0), .rd(rd0), .wd(wd0), .size(size0), .addr(addr0), .data_in(din0),
    .ready(ready0), .busy(busy0), .done(done0), .fault(fault0), .data_out(dout0));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One access on DUT A; returns fault, data_out at done, and accept->done latency.
  task automatic access(input logic r, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic f, output logic [31:0] dq, output int lat);
    @(negedge clk);
    check("ready_before_req", 32'(ready1), 32'd1);
    rd1 = r; wd1 = w; size1 = sz; addr1 = a; din1 = d;
    @(negedge clk);
    rd1 = 1'b0; wd1 = 1'b0; size1 = 2'b0; addr1 = 32'h0; din1 = 32'h0;
    lat = 1;
    while (!done1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    f  = fault1;
    dq = dout1;
  endtask

  typedef struct {
    logic        r, w;
    logic [1:0]  sz;
    logic [31:0] a, d;
    logic        ef;
    logic [31:0] edq;
  } vec_t;

  // Reference model: plain byte array over a region, little-endian
  logic [7:0]  mb [0:4095];
  logic [31:0] m_dout;

  function automatic logic model_fault(input logic r, input logic w, input logic [1:0] sz,
                                       input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    model_fault = (r && w) || (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
                  (sz == 2'd2 && (a % 4) != 0) || (off >= 32'(DEP * 4));
  endfunction

  task automatic model_apply(input logic r, input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d);
    int off, n;
    if (model_fault(r, w, sz, a)) return;
    off = int'(a - BASE);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (w) for (int i = 0; i < n; i++) mb[off + i] = d[8*i +: 8];
    if (r) begin
      m_dout = 32'h0;
      for (int i = 0; i < n; i++) m_dout[8*i +: 8] = mb[off + i];
    end
  endtask

  vec_t tbl [13];

  initial begin
    logic        f;
    logic [31:0] dq;
    int          lat;

    tbl[0]  = '{1'b0, 1'b1, 2'd2, BASE + 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'd2, BASE + 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, BASE + 32'h13, 32'h0000005A, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 2'd2, BASE + 32'h10, 32'h0,        1'b0, 32'h5AADBEEF};
    tbl[4]  = '{1'b1, 1'b0, 2'd1, BASE + 32'h12, 32'h0,        1'b0, 32'h00005AAD};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, BASE + 32'h11, 32'h0,        1'b0, 32'h000000BE};
    tbl[6]  = '{1'b1, 1'b0, 2'd1, BASE + 32'h1,  32'h0,        1'b1, 32'h000000BE};
    tbl[7]  = '{1'b0, 1'b1, 2'd2, BASE + 32'h12, 32'hFFFFFFFF, 1'b1, 32'h000000BE};
    tbl[8]  = '{1'b1, 1'b0, 2'd3, BASE + 32'h10, 32'h0,        1'b1, 32'h000000BE};
    tbl[9]  = '{1'b1, 1'b1, 2'd2, BASE + 32'h10, 32'hFFFFFFFF, 1'b1, 32'h000000BE};
    tbl[10] = '{1'b1, 1'b0, 2'd2, BASE + 32'h1000, 32'h0,      1'b1, 32'h000000BE};
    tbl[11] = '{1'b1, 1'b0, 2'd2, BASE - 32'h4,  32'h0,        1'b1, 32'h000000BE};
    tbl[12] = '{1'b1, 1'b0, 2'd2, BASE + 32'h10, 32'h0,        1'b0, 32'h5AADBEEF};

    // Reset both DUTs for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst0 = 1'b0;
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_busy",  32'(busy1),  32'd0);
    check("rst_done",  32'(done1),  32'd0);
    check("rst_fault", 32'(fault1), 32'd0);
    check("rst_dout",  dout1,       32'h0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      access(tbl[i].r, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, f, dq, lat);
      check($sformatf("tbl%0d_fault", i), 32'(f), 32'(tbl[i].ef));
      check($sformatf("tbl%0d_lat", i), 32'(lat), tbl[i].ef ? 32'd1 : 32'(WS + 1));
      check($sformatf("tbl%0d_dout", i), dq, tbl[i].edq);
    end
    m_dout = 32'h5AADBEEF;

    // Initialise random region BASE+0x40..0x7F, then random accesses vs model
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b1, 2'd2, BASE + 32'h40 + 32'(4 * i), 32'h0, f, dq, lat);
      model_apply(1'b0, 1'b1, 2'd2, BASE + 32'h40 + 32'(4 * i), 32'h0);
    end
    for (int n = 0; n < 300; n++) begin
      logic r, w, ef;
      logic [1:0]  sz;
      logic [31:0] a, d;
      int k;
      k = int'($urandom_range(0, 15));
      r = (k < 7) || (k == 15);
      w = (k >= 7);
      sz = 2'($urandom_range(0, 3));
      a = (k == 14) ? 32'h0000_3000 + 32'($urandom_range(0, 255))
                    : BASE + 32'h40 + 32'($urandom_range(0, 60));
      d = $urandom;
      ef = model_fault(r, w, sz, a);
      access(r, w, sz, a, d, f, dq, lat);
      model_apply(r, w, sz, a, d);
      check($sformatf("rnd%0d_fault", n), 32'(f), 32'(ef));
      check($sformatf("rnd%0d_lat", n), 32'(lat), ef ? 32'd1 : 32'(WS + 1));
      check($sformatf("rnd%0d_dout", n), dq, m_dout);
    end

    // Reset on the commit edge aborts the write
    access(1'b0, 1'b1, 2'd2, BASE + 32'h20, 32'h0, f, dq, lat);
    @(negedge clk);
    wd1 = 1'b1; size1 = 2'd2; addr1 = BASE + 32'h20; din1 = 32'h12345678;
    @(negedge clk);
    wd1 = 1'b0; rst1 = 1'b1;
    check("midrst_busy_before", 32'(busy1), 32'd1);
    @(negedge clk);
    rst1 = 1'b0;
    check("midrst_ready", 32'(ready1), 32'd1);
    check("midrst_done",  32'(done1),  32'd0);
    check("midrst_dout",  dout1,       32'h0);
    access(1'b1, 1'b0, 2'd2, BASE + 32'h20, 32'h0, f, dq, lat);
    check("midrst_readback", dq, 32'h0);
    check("midrst_rb_fault", 32'(f), 32'd0);

    // Back-to-back with WAIT_STATES=0: request held, accept every other edge
    @(negedge clk);
    rd0 = 1'b1; size0 = 2'd2; addr0 = 32'h8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_ready", i), 32'(ready0), (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("b2b%0d_done", i),  32'(done0),  (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b%0d_fault", i), 32'(fault0), 32'd0);
    end
    rd0 = 1'b0;
    // Faulted access on DUT B also completes in one cycle
    @(negedge clk);
    @(negedge clk);
    rd0 = 1'b1; size0 = 2'd2; addr0 = 32'h100;
    @(negedge clk);
    rd0 = 1'b0;
    check("b_oor_done",  32'(done0),  32'd1);
    check("b_oor_fault", 32'(fault0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
